// File: rtl/pi1_ramslv_pkg.sv
// Shared PerInt definitions for the pi1 RAM slave: op encodings, FSM states
// and the clog2 helper used to size address slices.
package pi1_ramslv_pkg;

  typedef logic [1:0] pi_op_t;

  localparam pi_op_t PINOOP = 2'b00;
  localparam pi_op_t PIWROP = 2'b01;
  localparam pi_op_t PIRDOP = 2'b10;
  localparam pi_op_t PIRWOP = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pi1_ramslv_if.sv
// pi1 bus bundle between the memory-side queue (master) and a responder (slave).
interface pi1_ramslv_if
  import pi1_ramslv_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8)
);

  pi_op_t                   pi1_op_i;
  logic [ADDRBITSZ-1:0]     pi1_addr_i;
  logic [ARCHBITSZ-1:0]     pi1_data_i;
  logic [ARCHBITSZ/8-1:0]   pi1_sel_i;
  logic [ARCHBITSZ-1:0]     pi1_data_o;
  logic                     pi1_rdy_o;

  modport master (
    output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    input  pi1_data_o, pi1_rdy_o
  );

  modport slave (
    input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    output pi1_data_o, pi1_rdy_o
  );

endinterface

// File: rtl/pi1_ramslv_mem.sv
// Single-port synchronous RAM with per-byte write enables; the read port
// returns the pre-write contents when read and write hit the same edge.
module pi1_ramslv_mem
  import pi1_ramslv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = clog2(DEPTH),
  localparam int NB   = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             re_i,
  input  logic [NB-1:0]    we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (we_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Output register only updates on a read, so the last response is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (en_i && re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pi1_ramslv.sv
// pi1 RAM responder: IDLE/BUSY FSM, op latches and wait-state counter around
// a byte-writable RAM; READWRITE is an atomic swap on the commit edge.
module pi1_ramslv
  import pi1_ramslv_pkg::*;
#(
  parameter int ARCHBITSZ  = 32,
  parameter int SIZE       = 1024,
  parameter int WAITSTATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pi1_ramslv_if.slave   pi1
);

  localparam int NB   = ARCHBITSZ / 8;
  localparam int IDXW = clog2(SIZE);

  logic [0:0]           state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  pi_op_t               op_q, op_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [ARCHBITSZ-1:0] data_q, data_d;
  logic [NB-1:0]        sel_q, sel_d;
  logic                 commit;
  logic                 mem_en;
  logic                 mem_re;
  logic [NB-1:0]        mem_we;
  logic                 unused_addr;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sel_d   = sel_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pi1.pi1_op_i != PINOOP) begin
          state_d = ST_BUSY;
          op_d    = pi1.pi1_op_i;
          idx_d   = pi1.pi1_addr_i[IDXW-1:0];
          data_d  = pi1.pi1_data_i;
          sel_d   = pi1.pi1_sel_i;
          wcnt_d  = 4'(WAITSTATES);
        end
      end
      default: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      op_q    <= PINOOP;
      idx_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  // Reset on the commit edge must suppress the RAM write as well.
  assign mem_en = commit && rst_i;
  assign mem_re = (op_q == PIRDOP) || (op_q == PIRWOP);
  assign mem_we = ((op_q == PIWROP) || (op_q == PIRWOP)) ? sel_q : '0;

  pi1_ramslv_mem #(
    .WIDTH (ARCHBITSZ),
    .DEPTH (SIZE)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (mem_en),
    .re_i    (mem_re),
    .we_i    (mem_we),
    .addr_i  (idx_q),
    .wdata_i (data_q),
    .rdata_o (pi1.pi1_data_o)
  );

  assign pi1.pi1_rdy_o = (state_q == ST_IDLE);
  assign unused_addr   = ^pi1.pi1_addr_i;

endmodule

// File: tb/tb_pi1_ramslv.sv
// Randomized self-checking bench for pi1_ramslv: two instances (0 and 3 wait
// states) driven in turn and compared against an array-based memory model.
module tb_pi1_ramslv;
  import pi1_ramslv_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic [1:0]  op_v   [2];
  logic [29:0] addr_v [2];
  logic [31:0] data_v [2];
  logic [3:0]  sel_v  [2];
  logic [31:0] dout_w [2];
  logic        rdy_w  [2];

  pi1_ramslv_if #(.ARCHBITSZ(32)) bus0 ();
  pi1_ramslv_if #(.ARCHBITSZ(32)) bus1 ();

  assign bus0.pi1_op_i   = op_v[0];
  assign bus0.pi1_addr_i = addr_v[0];
  assign bus0.pi1_data_i = data_v[0];
  assign bus0.pi1_sel_i  = sel_v[0];
  assign dout_w[0]       = bus0.pi1_data_o;
  assign rdy_w[0]        = bus0.pi1_rdy_o;

  assign bus1.pi1_op_i   = op_v[1];
  assign bus1.pi1_addr_i = addr_v[1];
  assign bus1.pi1_data_i = data_v[1];
  assign bus1.pi1_sel_i  = sel_v[1];
  assign dout_w[1]       = bus1.pi1_data_o;
  assign rdy_w[1]        = bus1.pi1_rdy_o;

  pi1_ramslv #(.ARCHBITSZ(32), .SIZE(DEPTH), .WAITSTATES(0)) u_dut0 (
    .clk_i (clk), .rst_i (rst_n[0]), .pi1 (bus0)
  );
  pi1_ramslv #(.ARCHBITSZ(32), .SIZE(DEPTH), .WAITSTATES(3)) u_dut1 (
    .clk_i (clk), .rst_i (rst_n[1]), .pi1 (bus1)
  );

  // Reference: plain word array per instance plus the last response word.
  logic [31:0] ref_mem  [2][DEPTH];
  logic [31:0] ref_dout [2];

  int total = 0;
  int bad   = 0;

  function automatic int wsOf(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void refOp(input int k, input logic [1:0] op, input logic [29:0] addr,
                                input logic [31:0] data, input logic [3:0] sel);
    int idx;
    logic [31:0] old;
    idx = int'(addr) % DEPTH;
    old = ref_mem[k][idx];
    if (op == PIRDOP || op == PIRWOP) ref_dout[k] = old;
    if (op == PIWROP || op == PIRWOP) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) ref_mem[k][idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endfunction

  task automatic driveOp(input int k, input logic [1:0] op, input logic [29:0] addr,
                         input logic [31:0] data, input logic [3:0] sel);
    op_v[k]   = op;
    addr_v[k] = addr;
    data_v[k] = data;
    sel_v[k]  = sel;
  endtask

  // One op from a negedge with rdy high; garbage is driven while busy.
  task automatic applyStimulus(input int k, input logic [1:0] op, input logic [29:0] addr,
                               input logic [31:0] data, input logic [3:0] sel, input string tag);
    int busy;
    busy = 0;
    checkOutput({tag, "_rdy_idle"}, 64'(rdy_w[k]), 64'd1);
    driveOp(k, op, addr, data, sel);
    @(posedge clk);
    while (busy < 40) begin
      @(negedge clk);
      if (rdy_w[k]) break;
      busy++;
      driveOp(k, 2'($urandom), 30'($urandom), $urandom, 4'($urandom));
    end
    driveOp(k, PINOOP, 30'($urandom), $urandom, 4'($urandom));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(wsOf(k) + 1));
    refOp(k, op, addr, data, sel);
    checkOutput({tag, "_data"}, 64'(dout_w[k]), 64'(ref_dout[k]));
  endtask

  task automatic noopCheck(input int k);
    driveOp(k, PINOOP, 30'($urandom), $urandom, 4'($urandom));
    @(negedge clk);
    checkOutput("noop_rdy", 64'(rdy_w[k]), 64'd1);
    checkOutput("noop_hold", 64'(dout_w[k]), 64'(ref_dout[k]));
  endtask

  // Reset during busy cycle 'cyc' (1-based); the write must not land.
  task automatic abortWrite(input int k, input logic [29:0] addr, input int cyc);
    driveOp(k, PIWROP, addr, $urandom | 32'h100, 4'hF);
    @(posedge clk);
    for (int c = 1; c <= cyc; c++) begin
      @(negedge clk);
      if (c == cyc) begin
        rst_n[k] = 1'b0;
        driveOp(k, PINOOP, '0, '0, '0);
      end
    end
    @(negedge clk);
    ref_dout[k] = '0;
    checkOutput("abort_rdy", 64'(rdy_w[k]), 64'd1);
    checkOutput("abort_data", 64'(dout_w[k]), 64'd0);
    rst_n[k] = 1'b1;
  endtask

  task automatic backToBack(input int k, input int n);
    logic [1:0]  ops   [8];
    logic [29:0] addrs [8];
    logic [31:0] datas [8];
    logic [3:0]  sels  [8];
    int cycles;
    int idx;
    for (int i = 0; i < n; i++) begin
      ops[i]   = 2'($urandom_range(1, 3));
      addrs[i] = (30'($urandom) & 30'h3FFFFC00) | 30'($urandom_range(0, 3));
      datas[i] = $urandom;
      sels[i]  = 4'($urandom);
    end
    cycles = 0;
    idx    = 0;
    driveOp(k, ops[0], addrs[0], datas[0], sels[0]);
    while (idx < n && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (rdy_w[k]) begin
        refOp(k, ops[idx], addrs[idx], datas[idx], sels[idx]);
        checkOutput("b2b_data", 64'(dout_w[k]), 64'(ref_dout[k]));
        idx++;
        if (idx < n) driveOp(k, ops[idx], addrs[idx], datas[idx], sels[idx]);
        else driveOp(k, PINOOP, '0, '0, '0);
      end
    end
    checkOutput("b2b_ops", 64'(idx), 64'(n));
    checkOutput("b2b_cycles", 64'(cycles), 64'(n * (wsOf(k) + 2)));
    // Read back the touched words to catch lost or duplicated writes.
    for (int a = 0; a < 4; a++) applyStimulus(k, PIRDOP, 30'(a), '0, '0, "b2b_readback");
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      driveOp(k, PINOOP, '0, '0, '0);
      ref_dout[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_rdy", 64'(rdy_w[k]), 64'd1);
      checkOutput("reset_data", 64'(dout_w[k]), 64'd0);
      rst_n[k] = 1'b1;
    end

    // Directed byte-merge / swap sequence on the zero-wait instance.
    applyStimulus(0, PIWROP, 30'h10, 32'hDEADBEEF, 4'hF, "wr_full");
    applyStimulus(0, PIRDOP, 30'h10, 32'h0, 4'h0, "rd_full");
    applyStimulus(0, PIWROP, 30'h10, 32'h11223344, 4'b0101, "wr_merge");
    applyStimulus(0, PIRDOP, 30'h10, 32'h0, 4'h0, "rd_merge");
    checkOutput("merge_value", 64'(dout_w[0]), 64'hDE22BE44);
    applyStimulus(0, PIRWOP, 30'h10, 32'hCAFEF00D, 4'hF, "rw_swap");
    checkOutput("swap_old", 64'(dout_w[0]), 64'hDE22BE44);
    applyStimulus(0, PIRDOP, 30'h10, 32'h0, 4'h0, "rd_after_swap");
    checkOutput("swap_new", 64'(dout_w[0]), 64'hCAFEF00D);
    applyStimulus(0, PIWROP, 30'h10, 32'h55555555, 4'h0, "wr_sel0");
    applyStimulus(0, PIRDOP, 30'h10, 32'h0, 4'h0, "rd_sel0");
    noopCheck(0);

    // Preload the small working set so every model read is defined.
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) applyStimulus(k, PIWROP, 30'(a), $urandom, 4'hF, "preload");
      applyStimulus(k, PIWROP, 30'h20, 32'd7, 4'hF, "preload20");
    end

    // Aliasing with wait states.
    applyStimulus(1, PIWROP, 30'h410, 32'd5, 4'hF, "ws3_wr_alias");
    applyStimulus(1, PIRDOP, 30'h010, 32'h0, 4'h0, "ws3_rd_alias");
    checkOutput("alias_value", 64'(dout_w[1]), 64'd5);

    // Aborted writes: mid-busy on ws3, coinciding with commit on ws0.
    abortWrite(1, 30'h20, 2);
    applyStimulus(1, PIRDOP, 30'h20, 32'h0, 4'h0, "abort_rd_ws3");
    checkOutput("abort_keep_ws3", 64'(dout_w[1]), 64'd7);
    abortWrite(0, 30'h20, 1);
    applyStimulus(0, PIRDOP, 30'h20, 32'h0, 4'h0, "abort_rd_ws0");
    checkOutput("abort_keep_ws0", 64'(dout_w[0]), 64'd7);

    // Random traffic with aliased addresses.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 7) == 0) noopCheck(k);
        else applyStimulus(k, 2'($urandom_range(1, 3)),
                           (30'($urandom) & 30'h3FFFFC00) | 30'($urandom_range(0, 15)),
                           $urandom, 4'($urandom), "rand");
      end
    end

    backToBack(0, 8);
    backToBack(1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
